// File: rtl/sum_acc_pkg.sv
// Shared types, default widths and signed-limit helpers for the sum_acc block accumulator.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 8;
  localparam int N_MAX_DEF = 16;
  localparam int CNT_W_DEF = 5;

  function automatic longint signed_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint signed_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sum_acc_sat_add.sv
// Combinational accumulate step: ACC_W + IN_W -> ACC_W with overflow flag.
// Build option: define SUM_ACC_SAT_EN to clamp on overflow; otherwise the sum wraps.
module sat_add
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  localparam int SW = ACC_W + 1;

  logic signed [SW-1:0] w_wide;

  // One guard bit is enough: an ACC_W + IN_W sum with IN_W <= ACC_W always fits in ACC_W+1.
  assign w_wide = SW'(i_acc) + SW'(i_data);
  assign o_ovf  = w_wide[SW-1] ^ w_wide[SW-2];

`ifdef SUM_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(signed_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(signed_min(ACC_W));

  // NOTE: o_sum gets a default before the conditional override so no latch is inferred.
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    if (o_ovf) o_sum = w_wide[SW-1] ? MIN_V : MAX_V;
  end
`else
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
  end
`endif

endmodule

// File: rtl/sum_acc.sv
// Signed block accumulator: sums up to N_MAX samples per block and holds the total until taken.
// Build option: SUM_ACC_SAT_EN (saturating accumulate, see sat_add).
module sum_acc
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int N_MAX = N_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_pos,
  output logic                    out_neg,
  output logic                    out_ovf
);

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_sum;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ovf;
  logic                     r_pos;
  logic                     r_neg;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic signed [ACC_W-1:0]  w_add_sum;
  logic                     w_step_ovf;
  logic signed [ACC_W-1:0]  w_next_sum;
  logic                     w_close;

  sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_acc  (r_sum),
    .i_data (in_data),
    .o_sum  (w_add_sum),
    .o_ovf  (w_step_ovf)
  );

  // The first beat of a block loads rather than adds, so stale totals never leak in.
  assign w_next_sum = (r_state == S_IDLE) ? ACC_W'(in_data) : w_add_sum;
  assign w_close    = in_last || (N_MAX == 1) ||
                      ((r_state == S_ACC) && (r_count == CNT_W'(N_MAX - 1)));

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_pos       <= 1'b0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ACC: begin
          if (in_valid) begin
            r_sum   <= w_next_sum;
            r_pos   <= !w_next_sum[ACC_W-1] && (|w_next_sum);
            r_neg   <= w_next_sum[ACC_W-1];
            r_count <= (r_state == S_IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
            r_ovf   <= (r_state == S_IDLE) ? 1'b0 : (r_ovf | w_step_ovf);
            if (w_close) begin
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_count = r_count;
  assign out_pos   = r_pos;
  assign out_neg   = r_neg;
  assign out_ovf   = r_ovf;

endmodule
